vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in clocks
- H_SYNC, 96, hsync width in clocks
- H_BP, 48, horizontal back porch in clocks
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch in lines
- SYNC_POL, 0, asserted level of vga_hsync and vga_vsync
- PIX_LAT, 1, clocks from pixel_x/pixel_y to valid pixel_r/g/b; legal range 0..4
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, pixel clock; the only clock
- rst, in, 1, asynchronous active-low reset
- pixel_x, out, 10, current horizontal count sent to the draw logic
- pixel_y, out, 10, current vertical count sent to the draw logic
- pixel_r / pixel_g / pixel_b, in, 8 each, colour returned by the draw logic
- vga_r / vga_g / vga_b, out, 8 each, colour sent to the DAC
- vga_hsync, out, 1, horizontal sync
- vga_vsync, out, 1, vertical sync
- vga_blank_n, out, 1, high while the visible pixel is on the DAC
- frame_start, out, 1, one-clock pulse at the start of each frame
REQ-003 The module SHALL use one clock (clk) and an asynchronous, active-low reset (rst).

Function
REQ-004 h_cnt SHALL count 0..H_TOT-1, where H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP (800 at defaults), and SHALL wrap to 0.
REQ-005 v_cnt SHALL count 0..V_TOT-1, where V_TOT = V_ACTIVE+V_FP+V_SYNC+V_BP (525 at defaults).
REQ-006 v_cnt SHALL advance only in the cycle where h_cnt wraps, and SHALL wrap to 0 when it is at V_TOT-1 in that cycle.
REQ-007 pixel_x SHALL equal h_cnt and pixel_y SHALL equal v_cnt, driven directly from the registers with no added delay.
REQ-008 active SHALL be (h_cnt < H_ACTIVE) AND (v_cnt < V_ACTIVE).
REQ-009 hs_raw SHALL be true for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], which is [656,751] at defaults.
REQ-010 vs_raw SHALL be true for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], which is [490,491] at defaults.
REQ-011 active, hs_raw and vs_raw SHALL pass through a shift register PIX_LAT+1 stages deep, so that they align with the colour data.
REQ-012 The pixel_r/g/b sampled at cycle t SHALL be registered and driven on vga_r/g/b at t+1.
- This SHALL place vga outputs for counter value (x,y) exactly PIX_LAT+1 cycles after pixel_x/pixel_y = (x,y).
REQ-013 vga_r/g/b SHALL be forced to 0 whenever the delayed active is false.
REQ-014 vga_blank_n SHALL equal the delayed active.
REQ-015 vga_hsync SHALL equal SYNC_POL when the delayed hs_raw is true and ~SYNC_POL otherwise; vga_vsync SHALL use the same rule.
REQ-016 frame_start SHALL be high for exactly the one cycle in which h_cnt = 0 and v_cnt = 0, aligned with pixel_x/pixel_y and not delayed.
REQ-017 All outputs except pixel_x/pixel_y SHALL be driven from flops; there SHALL be no combinational path from pixel_r/g/b to any output.

Reset
REQ-018 While rst = 0, the block SHALL hold:
- h_cnt = v_cnt = 0, so pixel_x = pixel_y = 0
- every delay stage inactive, with syncs deasserted
- vga_r/g/b = 0, vga_blank_n = 0, vga_hsync = vga_vsync = ~SYNC_POL, frame_start = 0
REQ-019 On the first clk edge after rst rises, the counters SHALL go to (1,0).
- frame_start SHALL be high during the first post-reset cycle at (0,0).
REQ-020 Reset asserted mid-frame SHALL clear all state immediately, with no clock required.
- After release, the frame SHALL restart from (0,0), and no stale pipeline colour SHALL reach vga_r/g/b.

Verification
REQ-021 Wrap test: release reset, run 1600 cycles.
- h_cnt SHALL read 799 then 0, v_cnt SHALL step 0->1 at cycle 800, and no count SHALL exceed 799.
REQ-022 Sync test: run one full frame at defaults.
- vga_hsync SHALL be low for 96 clocks per line, starting PIX_LAT+1 clocks after pixel_x = 656.
- vga_vsync SHALL be low for 1600 clocks.
- frame_start pulses SHALL be exactly 420000 clocks apart.
REQ-023 Latency test: PIX_LAT = 1, and the bench returns pixel_r = pixel_x[7:0] one cycle late.
- vga_r SHALL equal the x value of the current pixel on every visible pixel, e.g. 0x05 two clocks after pixel_x = 5.
REQ-024 Blanking test: the bench holds pixel_r/g/b = 0xFF constantly.
- vga_r/g/b SHALL be 0 and vga_blank_n SHALL be 0 for all x >= 640 or y >= 480, including the PIX_LAT+1 clocks after each line's visible region ends.
REQ-025 Mid-frame reset test: pulse rst low for 3 cycles at (320,200).
- Outputs SHALL take their reset values at once.
- frame_start SHALL fire on the first cycle after release, and the next pulse SHALL follow 420000 clocks later.
REQ-026 Parameter test: PIX_LAT = 0 and SYNC_POL = 1.
- vga_hsync SHALL go high exactly 1 clock after pixel_x = 656.
- vga_r SHALL follow the combinational pixel_r by 1 clock.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters, draw-logic handshake,
// and a latency-matched pipeline that aligns blanking and syncs with returned colour.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0,
  parameter int   PIX_LAT  = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  input  logic [7:0] pixel_r,
  input  logic [7:0] pixel_g,
  input  logic [7:0] pixel_b,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       vga_blank_n,
  output logic       frame_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  function automatic logic [7:0] gate_colour(input logic en, input logic [7:0] c);
    return en ? c : 8'h00;
  endfunction

  function automatic logic sync_level(input logic asserted);
    return asserted ? SYNC_POL : ~SYNC_POL;
  endfunction

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic       h_wrap;
  logic       origin_q;

  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    h_nxt  = h_wrap ? 10'd0 : h_cnt + 10'd1;
    v_nxt  = v_cnt;
    if (h_wrap) begin
      v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end
  end

  // origin_q tracks "counters are at (0,0)" as a flop so frame_start needs no decode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt    <= 10'd0;
      v_cnt    <= 10'd0;
      origin_q <= 1'b1;
    end else begin
      h_cnt    <= h_nxt;
      v_cnt    <= v_nxt;
      origin_q <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
    end
  end

  assign pixel_x     = h_cnt;
  assign pixel_y     = v_cnt;
  // Gated by rst so the pulse is suppressed while held in reset yet present in the first cycle after
  assign frame_start = rst & origin_q;

  logic active;
  logic hs_raw;
  logic vs_raw;

  always_comb begin
    active = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hs_raw = (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
    vs_raw = (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
  end

  // ---- stage boundary: counters -> PIX_LAT+1 deep control delay line ----
  logic [PIX_LAT:0]   act_p;
  logic [PIX_LAT:0]   hs_p;
  logic [PIX_LAT:0]   vs_p;
  logic [PIX_LAT+1:0] act_tap;
  logic [PIX_LAT+1:0] hs_tap;
  logic [PIX_LAT+1:0] vs_tap;

  assign act_tap = {act_p, active};
  assign hs_tap  = {hs_p, hs_raw};
  assign vs_tap  = {vs_p, vs_raw};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_p <= '0;
      hs_p  <= '0;
      vs_p  <= '0;
    end else begin
      act_p <= act_tap[PIX_LAT:0];
      hs_p  <= hs_tap[PIX_LAT:0];
      vs_p  <= vs_tap[PIX_LAT:0];
    end
  end

  // ---- stage boundary: returned colour -> DAC register ----
  // act_tap[PIX_LAT] is the visibility of the pixel whose colour is arriving now
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_r <= 8'h00;
      vga_g <= 8'h00;
      vga_b <= 8'h00;
    end else begin
      vga_r <= gate_colour(act_tap[PIX_LAT], pixel_r);
      vga_g <= gate_colour(act_tap[PIX_LAT], pixel_g);
      vga_b <= gate_colour(act_tap[PIX_LAT], pixel_b);
    end
  end

  assign vga_blank_n = act_p[PIX_LAT];
  assign vga_hsync   = sync_level(hs_p[PIX_LAT]);
  assign vga_vsync   = sync_level(vs_p[PIX_LAT]);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances (PIX_LAT=1/SYNC_POL=0 and PIX_LAT=0/SYNC_POL=1)
// on a small raster, random colour returned by emulated draw logic, queued expectations.
module tb_vga_timing_gen;

  localparam int HA = 20, HF = 4, HS = 5, HB = 3;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [9:0] pixel_x_a, pixel_y_a, pixel_x_b, pixel_y_b;
  logic [7:0] pix_r_a, pix_g_a, pix_b_a, pix_r_b, pix_g_b, pix_b_b;
  logic [7:0] vga_r_a, vga_g_a, vga_b_a, vga_r_b, vga_g_b, vga_b_b;
  logic       hsync_a, vsync_a, blank_n_a, fs_a;
  logic       hsync_b, vsync_b, blank_n_b, fs_b;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .PIX_LAT(1)
  ) u_dut_a (
    .clk(clk), .rst(rst),
    .pixel_x(pixel_x_a), .pixel_y(pixel_y_a),
    .pixel_r(pix_r_a), .pixel_g(pix_g_a), .pixel_b(pix_b_a),
    .vga_r(vga_r_a), .vga_g(vga_g_a), .vga_b(vga_b_a),
    .vga_hsync(hsync_a), .vga_vsync(vsync_a),
    .vga_blank_n(blank_n_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1), .PIX_LAT(0)
  ) u_dut_b (
    .clk(clk), .rst(rst),
    .pixel_x(pixel_x_b), .pixel_y(pixel_y_b),
    .pixel_r(pix_r_b), .pixel_g(pix_g_b), .pixel_b(pix_b_b),
    .vga_r(vga_r_b), .vga_g(vga_g_b), .vga_b(vga_b_b),
    .vga_hsync(hsync_b), .vga_vsync(vsync_b),
    .vga_blank_n(blank_n_b), .frame_start(fs_b)
  );

  typedef struct {
    int          cyc;
    int          x;
    int          y;
    logic        fs;
    logic [23:0] rgb_a;
    logic        blank_a, hs_a, vs_a;
    logic [23:0] rgb_b;
    logic        blank_b, hs_b, vs_b;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   c      = 0;
  int   mode   = 0;

  // Reference raster: cycle p after reset release shows pixel (p mod HT, p/HT mod VT)
  function automatic int px(input int p); return p % HT; endfunction
  function automatic int py(input int p); return (p / HT) % VT; endfunction
  function automatic logic vis(input int p);
    return (p >= 0) && (px(p) < HA) && (py(p) < VA);
  endfunction
  function automatic logic hsr(input int p);
    return (p >= 0) && (px(p) >= HA + HF) && (px(p) < HA + HF + HS);
  endfunction
  function automatic logic vsr(input int p);
    return (p >= 0) && (py(p) >= VA + VF) && (py(p) < VA + VF + VS);
  endfunction

  // Draw-logic response for pixel p; p < 0 means no pixel yet, so junk is returned
  function automatic logic [23:0] colour(input int p);
    logic [7:0] xb, yb;
    if (p < 0) return 24'($urandom);
    xb = 8'(px(p));
    yb = 8'(py(p));
    case (mode)
      0:       return 24'($urandom);
      1:       return {xb, yb, xb ^ yb};
      default: return 24'hFFFFFF;
    endcase
  endfunction

  task automatic chk(input string name, input int cyc, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " cnt_a"}, -1, 64'({pixel_x_a, pixel_y_a, fs_a}), 64'(0));
    chk({tag, " cnt_b"}, -1, 64'({pixel_x_b, pixel_y_b, fs_b}), 64'(0));
    chk({tag, " vid_a"}, -1, 64'({vga_r_a, vga_g_a, vga_b_a, blank_n_a, hsync_a, vsync_a}),
        64'({24'h0, 1'b0, 1'b1, 1'b1}));
    chk({tag, " vid_b"}, -1, 64'({vga_r_b, vga_g_b, vga_b_b, blank_n_b, hsync_b, vsync_b}),
        64'({24'h0, 1'b0, 1'b0, 1'b0}));
  endtask

  task automatic chk_start(input string tag);
    chk({tag, " cnt_a"}, 0, 64'({pixel_x_a, pixel_y_a, fs_a}), 64'({10'd0, 10'd0, 1'b1}));
    chk({tag, " cnt_b"}, 0, 64'({pixel_x_b, pixel_y_b, fs_b}), 64'({10'd0, 10'd0, 1'b1}));
    chk({tag, " vid_a"}, 0, 64'({vga_r_a, vga_g_a, vga_b_a, blank_n_a, hsync_a, vsync_a}),
        64'({24'h0, 1'b0, 1'b1, 1'b1}));
    chk({tag, " vid_b"}, 0, 64'({vga_r_b, vga_g_b, vga_b_b, blank_n_b, hsync_b, vsync_b}),
        64'({24'h0, 1'b0, 1'b0, 1'b0}));
  endtask

  // One cycle of stimulus: drive colour for the pixel each DUT asked for PIX_LAT cycles ago,
  // and queue what both DUTs must show after the next clock edge.
  task automatic step();
    exp_t        e;
    logic [23:0] ca, cb;
    int          pa, pb;
    @(negedge clk);
    if (px(c) == 0 && py(c) == 0) mode = int'($urandom_range(0, 2));
    pa = c - 1;
    pb = c;
    ca = colour(pa);
    cb = colour(pb);
    {pix_r_a, pix_g_a, pix_b_a} = ca;
    {pix_r_b, pix_g_b, pix_b_b} = cb;
    e.cyc     = c + 1;
    e.x       = px(c + 1);
    e.y       = py(c + 1);
    e.fs      = (e.x == 0) && (e.y == 0);
    e.blank_a = vis(pa);
    e.rgb_a   = vis(pa) ? ca : 24'h0;
    e.hs_a    = ~hsr(pa);
    e.vs_a    = ~vsr(pa);
    e.blank_b = vis(pb);
    e.rgb_b   = vis(pb) ? cb : 24'h0;
    e.hs_b    = hsr(pb);
    e.vs_b    = vsr(pb);
    sb.push_back(e);
    c++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("cnt_a", e.cyc, 64'({pixel_x_a, pixel_y_a, fs_a}), 64'({10'(e.x), 10'(e.y), e.fs}));
        chk("cnt_b", e.cyc, 64'({pixel_x_b, pixel_y_b, fs_b}), 64'({10'(e.x), 10'(e.y), e.fs}));
        chk("vid_a", e.cyc, 64'({vga_r_a, vga_g_a, vga_b_a, blank_n_a, hsync_a, vsync_a}),
            64'({e.rgb_a, e.blank_a, e.hs_a, e.vs_a}));
        chk("vid_b", e.cyc, 64'({vga_r_b, vga_g_b, vga_b_b, blank_n_b, hsync_b, vsync_b}),
            64'({e.rgb_b, e.blank_b, e.hs_b, e.vs_b}));
      end
    end
  end

  initial begin
    {pix_r_a, pix_g_a, pix_b_a} = 24'h0;
    {pix_r_b, pix_g_b, pix_b_b} = 24'h0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 chk_reset("por");
    repeat (3) @(posedge clk);
    #1 chk_reset("por_held");
    #1 rst = 1'b1;
    c = 0;
    #1 chk_start("start");
    run(900);

    // Mid-frame asynchronous reset between clock edges
    #2;
    sb.delete();
    rst = 1'b0;
    #1 chk_reset("mid");
    repeat (3) @(posedge clk);
    #1 chk_reset("mid_held");
    #1 rst = 1'b1;
    c = 0;
    #1 chk_start("restart");
    run(900);

    @(posedge clk);
    #2;
    chk("sb_drain", -1, 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
